// File: rtl/stream_mem_loader_if.sv
// stream_mem_loader_if: incoming byte stream plus instruction-memory write port.
// Signal names follow the loader's point of view (_i into the loader, _o out of it).
interface stream_mem_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  byte_valid_i;
    logic [7:0]            byte_data_i;
    logic                  byte_ready_o;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;

    // Loader side: consumes bytes, drives memory requests
    modport master (
        input  byte_valid_i,
        input  byte_data_i,
        output byte_ready_o,
        output mem_req_o,
        output mem_addr_o,
        output mem_we_o,
        output mem_be_o,
        output mem_wdata_o,
        input  mem_gnt_i,
        input  mem_rvalid_i
    );

    // Environment side: byte source and memory
    modport slave (
        output byte_valid_i,
        output byte_data_i,
        input  byte_ready_o,
        input  mem_req_o,
        input  mem_addr_o,
        input  mem_we_o,
        input  mem_be_o,
        input  mem_wdata_o,
        output mem_gnt_i,
        output mem_rvalid_i
    );
endinterface

// File: rtl/stream_mem_loader.sv
// stream_mem_loader: receives a little-endian word count followed by that many
// little-endian 32-bit words over a byte stream and writes them to consecutive
// word addresses starting at BASE_ADDR, holding the core in reset meanwhile.
module stream_mem_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BASE_ADDR  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    stream_mem_loader_if.master bus,
    output logic                core_rst_n_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);
    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        REQ,
        ACK,
        DONE
    } state_e;

    // Largest word count that fits between BASE_ADDR and the top of memory
    localparam logic [63:0] MAX_WORDS = (64'd1 << (ADDR_WIDTH - 2)) - 64'(BASE_ADDR / 4);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_e                state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           remain_q, remain_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  mem_req_q, mem_req_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  xfer;
    logic [31:0]           n_word;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        word_d   = word_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        err_d    = err_q;
        xfer     = bus.byte_valid_i & byte_ready_q;
        n_word   = {bus.byte_data_i, word_q[23:0]};

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = LEN;
                    err_d   = 1'b0;
                    addr_d  = BASE;
                    lane_d  = '0;
                end
            end
            LEN: begin
                if (xfer) begin
                    word_d[{lane_q, 3'b000} +: 8] = bus.byte_data_i;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        remain_d = n_word;
                        if (n_word == 32'd0) begin
                            state_d = DONE;
                        end else if ({32'd0, n_word} > MAX_WORDS) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    word_d[{lane_q, 3'b000} +: 8] = bus.byte_data_i;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.mem_gnt_i) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (bus.mem_rvalid_i) begin
                    remain_d = remain_q - 32'd1;
                    // Address advances only when another word follows, so a load
                    // that fills memory to the top never wraps the counter.
                    if (remain_q == 32'd1) begin
                        state_d = DONE;
                    end else begin
                        state_d = DATA;
                        addr_d  = addr_q + ADDR_WIDTH'(4);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d == LEN) || (state_d == DATA) ||
                       (state_d == REQ) || (state_d == ACK);
        core_rst_n_d = !busy_d;
        byte_ready_d = (state_d == LEN) || (state_d == DATA);
        mem_req_d    = (state_d == REQ);
        done_d       = (state_d == DONE);
    end

    // State and output registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            word_q       <= '0;
            addr_q       <= '0;
            remain_q     <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            byte_ready_q <= 1'b0;
            mem_req_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            err_q        <= err_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            byte_ready_q <= byte_ready_d;
            mem_req_q    <= mem_req_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign bus.byte_ready_o = byte_ready_q;
    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_we_o     = mem_req_q;
    assign bus.mem_be_o     = {4{mem_req_q}};
    assign bus.mem_wdata_o  = word_q;
    assign core_rst_n_o     = core_rst_n_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
endmodule

// File: tb/tb_stream_mem_loader.sv
// tb_stream_mem_loader: directed scenarios for stream_mem_loader with a
// negedge-driven memory responder (configurable grant/rvalid delays and
// optional spurious gnt/rvalid outside the states that use them).
module tb_stream_mem_loader;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic core_rst_n, busy, done, err;

    int checks = 0;
    int errors = 0;

    stream_mem_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    stream_mem_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .bus          (bus),
        .core_rst_n_o (core_rst_n),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // Responder configuration and observations
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    bit          noise     = 1'b0;
    int          gcnt      = 0;
    int          rv_wait   = 0;
    bit          rv_pending = 1'b0;
    bit          in_req    = 1'b0;
    logic [15:0] ref_addr;
    logic [31:0] ref_data;
    int          stable_err  = 0;
    int          busbits_err = 0;
    int          req_cycles  = 0;
    int          byte_to     = 0;
    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];

    // Memory model: grants after gnt_delay REQ cycles, completes after rv_delay ACK cycles
    initial begin
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            if (!rst_n) begin
                rv_pending = 1'b0;
                gcnt       = 0;
                in_req     = 1'b0;
            end else if (rv_pending) begin
                bus.mem_gnt_i = noise;
                if (rv_wait == 0) begin
                    bus.mem_rvalid_i = 1'b1;
                    rv_pending       = 1'b0;
                end else begin
                    rv_wait--;
                end
            end else if (bus.mem_req_o === 1'b1) begin
                req_cycles++;
                if (bus.mem_we_o !== 1'b1 || bus.mem_be_o !== 4'hF) busbits_err++;
                if (!in_req) begin
                    in_req   = 1'b1;
                    ref_addr = bus.mem_addr_o;
                    ref_data = bus.mem_wdata_o;
                end else if (bus.mem_addr_o !== ref_addr || bus.mem_wdata_o !== ref_data) begin
                    stable_err++;
                end
                bus.mem_rvalid_i = noise;
                if (gcnt == gnt_delay) begin
                    bus.mem_gnt_i = 1'b1;
                    gcnt          = 0;
                    in_req        = 1'b0;
                    rv_pending    = 1'b1;
                    rv_wait       = rv_delay;
                    wr_addr.push_back(bus.mem_addr_o);
                    wr_data.push_back(bus.mem_wdata_o);
                end else begin
                    gcnt++;
                end
            end else begin
                in_req           = 1'b0;
                gcnt             = 0;
                bus.mem_gnt_i    = noise;
                bus.mem_rvalid_i = noise;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            bus.byte_valid_i = 1'b0;
            bus.byte_data_i  = 8'hEE;
            @(negedge clk);
        end
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = b;
        n = 0;
        while (bus.byte_ready_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) byte_to++;
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.mem_req_o); end
        checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", bus.mem_we_o); end
        checks++; if (bus.mem_be_o !== 4'h0) begin errors++; $display("FAIL rst_be: got %h want 0", bus.mem_be_o); end
        checks++; if (bus.mem_addr_o !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr_o); end
        checks++; if (bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata_o); end
        checks++; if (bus.byte_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus.byte_ready_o); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rst_status: got busy/done/err=%b want 000", {busy, done, err}); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL rst_core_rst_n: got %b want 0", core_rst_n); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL idle_core_rst_n: got %b want 1", core_rst_n); end
        checks++; if ({busy, bus.byte_ready_o} !== 2'b00) begin errors++; $display("FAIL idle_busy_ready: got %b want 00", {busy, bus.byte_ready_o}); end
    endtask

    task automatic test_basic();
        wr_addr.delete(); wr_data.delete(); busbits_err = 0;
        pulse_start();
        checks++; if ({busy, core_rst_n, bus.byte_ready_o} !== 3'b101) begin errors++; $display("FAIL basic_len_state: got busy/core_rst_n/ready=%b want 101", {busy, core_rst_n, bus.byte_ready_o}); end
        send_word(32'd2, 0);
        send_word(32'h00000013, 0);
        send_word(32'h0000006F, 0);
        checks++; if (bus.mem_req_o !== 1'b1 || bus.byte_ready_o !== 1'b0) begin errors++; $display("FAIL basic_req_next: got req/ready=%b%b want 10", bus.mem_req_o, bus.byte_ready_o); end
        checks++; if (bus.mem_addr_o !== 16'h0004 || bus.mem_wdata_o !== 32'h6F) begin errors++; $display("FAIL basic_req2_bus: got %h/%h want 0004/0000006f", bus.mem_addr_o, bus.mem_wdata_o); end
        @(negedge clk);
        checks++; if ({bus.mem_req_o, busy, done} !== 3'b010) begin errors++; $display("FAIL basic_ack: got req/busy/done=%b want 010", {bus.mem_req_o, busy, done}); end
        @(negedge clk);
        checks++; if ({done, err, busy, core_rst_n} !== 4'b1001) begin errors++; $display("FAIL basic_done: got done/err/busy/core_rst_n=%b want 1001", {done, err, busy, core_rst_n}); end
        #1;
        checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL basic_wr_count: got %0d want 2", wr_addr.size()); end
        else begin
            checks++; if (wr_addr[0] !== 16'h0000 || wr_data[0] !== 32'h00000013) begin errors++; $display("FAIL basic_wr0: got %h@%h want 00000013@0000", wr_data[0], wr_addr[0]); end
            checks++; if (wr_addr[1] !== 16'h0004 || wr_data[1] !== 32'h0000006F) begin errors++; $display("FAIL basic_wr1: got %h@%h want 0000006f@0004", wr_data[1], wr_addr[1]); end
        end
        checks++; if (busbits_err != 0 || byte_to != 0) begin errors++; $display("FAIL basic_we_be: got we/be errors %0d, byte timeouts %0d want 0/0", busbits_err, byte_to); end
    endtask

    task automatic test_zero_len();
        req_cycles = 0;
        pulse_start();
        send_word(32'd0, 1);
        checks++; if ({done, err, busy} !== 3'b100) begin errors++; $display("FAIL zero_done: got done/err/busy=%b want 100", {done, err, busy}); end
        #1;
        checks++; if (req_cycles != 0) begin errors++; $display("FAIL zero_no_req: got %0d req cycles want 0", req_cycles); end
    endtask

    task automatic test_overflow();
        req_cycles = 0;
        pulse_start();
        send_word(32'h00004001, 0);
        checks++; if ({done, err, busy} !== 3'b110) begin errors++; $display("FAIL ovf_err: got done/err/busy=%b want 110", {done, err, busy}); end
        #1;
        checks++; if (req_cycles != 0) begin errors++; $display("FAIL ovf_no_req: got %0d req cycles want 0", req_cycles); end
        @(negedge clk);
        pulse_start();
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL ovf_restart_clear: got done/err=%b want 00", {done, err}); end
        send_word(32'h00004000, 0);
        checks++; if ({err, busy, bus.byte_ready_o} !== 3'b011) begin errors++; $display("FAIL ovf_limit_ok: got err/busy/ready=%b want 011", {err, busy, bus.byte_ready_o}); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int nreq;
        int nack;
        int bad;
        wr_addr.delete(); wr_data.delete(); stable_err = 0; busbits_err = 0;
        gnt_delay = 5; rv_delay = 3; noise = 1'b1;
        pulse_start();
        send_word(32'd1, 2);
        send_word(32'hDDCCBBAA, 1);
        nreq = 0;
        while (bus.mem_req_o === 1'b1 && nreq < 50) begin
            nreq++;
            @(negedge clk);
        end
        checks++; if (nreq != 6) begin errors++; $display("FAIL stall_req_cycles: got %0d want 6", nreq); end
        nack = 0; bad = 0;
        while (done !== 1'b1 && nack < 50) begin
            if (bus.byte_ready_o !== 1'b0 || bus.mem_req_o !== 1'b0) bad++;
            nack++;
            @(negedge clk);
        end
        checks++; if (nack != 4) begin errors++; $display("FAIL stall_ack_cycles: got %0d want 4", nack); end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_ack_quiet: got %0d cycles with ready/req high want 0", bad); end
        #1;
        checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL stall_wr_count: got %0d want 1", wr_addr.size()); end
        else begin
            checks++; if (wr_addr[0] !== 16'h0 || wr_data[0] !== 32'hDDCCBBAA) begin errors++; $display("FAIL stall_wr0: got %h@%h want ddccbbaa@0000", wr_data[0], wr_addr[0]); end
        end
        checks++; if (stable_err != 0 || busbits_err != 0) begin errors++; $display("FAIL stall_stable: got %0d unstable, %0d we/be errors want 0/0", stable_err, busbits_err); end
        gnt_delay = 0; rv_delay = 0; noise = 1'b0;
    endtask

    task automatic test_reset_in_req();
        bit ok;
        gnt_delay = 20;
        pulse_start();
        send_word(32'd1, 0);
        send_word(32'h12345678, 0);
        checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL rreq_in_req: got %b want 1", bus.mem_req_o); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.mem_req_o, busy, done, err, bus.byte_ready_o, core_rst_n} !== 6'b0) begin errors++; $display("FAIL rreq_async: got req/busy/done/err/ready/core_rst_n=%b want 000000", {bus.mem_req_o, busy, done, err, bus.byte_ready_o, core_rst_n}); end
        @(negedge clk);
        rst_n = 1'b1;
        gnt_delay = 0;
        @(negedge clk);
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_word(32'd2, 0);
        send_word(32'hCAFEF00D, 0);
        send_word(32'h0BADBEEF, 0);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rreq_reload_done: got timeout want done"); end
        #1;
        checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL rreq_wr_count: got %0d want 2", wr_addr.size()); end
        else begin
            checks++; if (wr_addr[0] !== 16'h0 || wr_data[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL rreq_wr0: got %h@%h want cafef00d@0000", wr_data[0], wr_addr[0]); end
            checks++; if (wr_addr[1] !== 16'h4 || wr_data[1] !== 32'h0BADBEEF) begin errors++; $display("FAIL rreq_wr1: got %h@%h want 0badbeef@0004", wr_data[1], wr_addr[1]); end
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        wr_addr.delete(); wr_data.delete();
        @(negedge clk);
        pulse_start();
        send_word(32'd3, 0);
        send_word(32'h11111111, 3);
        start = 1'b1;
        send_word(32'h22222222, 1);
        start = 1'b0;
        send_word(32'h33333333, 0);
        wait_done(ok);
        checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL sig_done: got ok=%0d err=%b want 1/0", ok, err); end
        #1;
        checks++; if (wr_addr.size() != 3) begin errors++; $display("FAIL sig_wr_count: got %0d want 3", wr_addr.size()); end
        else begin
            checks++; if (wr_addr[0] !== 16'h0 || wr_data[0] !== 32'h11111111) begin errors++; $display("FAIL sig_wr0: got %h@%h want 11111111@0000", wr_data[0], wr_addr[0]); end
            checks++; if (wr_addr[1] !== 16'h4 || wr_data[1] !== 32'h22222222) begin errors++; $display("FAIL sig_wr1: got %h@%h want 22222222@0004", wr_data[1], wr_addr[1]); end
            checks++; if (wr_addr[2] !== 16'h8 || wr_data[2] !== 32'h33333333) begin errors++; $display("FAIL sig_wr2: got %h@%h want 33333333@0008", wr_data[2], wr_addr[2]); end
        end
        @(negedge clk);
        pulse_start();
        checks++; if ({done, busy, bus.byte_ready_o} !== 3'b011) begin errors++; $display("FAIL restart_state: got done/busy/ready=%b want 011", {done, busy, bus.byte_ready_o}); end
        checks++; if (bus.mem_addr_o !== 16'h0) begin errors++; $display("FAIL restart_addr: got %h want 0000", bus.mem_addr_o); end
        send_word(32'd0, 0);
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL restart_done: got done/err=%b want 10", {done, err}); end
        checks++; if (byte_to != 0) begin errors++; $display("FAIL byte_timeouts: got %0d want 0", byte_to); end
    endtask

    initial begin
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_stall();
        test_reset_in_req();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_mem_loader.md
STREAM_MEM_LOADER -- requirements
Module: stream_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory byte-address width (matches instruction memory port).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width; only 32 supported.
REQ-003 SHALL have parameter BASE_ADDR, default 0, byte address of first word written.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start_i  input  1  one-cycle pulse requesting a new load.
REQ-007 byte_valid_i  input  1  incoming byte stream valid.
REQ-008 byte_data_i  input  8  incoming byte.
REQ-009 byte_ready_o  output  1  loader accepts byte this cycle (transfer = valid & ready).
REQ-010 mem_req_o  output  1  memory port request.
REQ-011 mem_addr_o  output  ADDR_WIDTH  byte address, word aligned.
REQ-012 mem_we_o  output  1  write enable; always 1 when mem_req_o=1.
REQ-013 mem_be_o  output  4  byte enables; always 4'b1111 when mem_req_o=1.
REQ-014 mem_wdata_o  output  32  write data.
REQ-015 mem_gnt_i  input  1  request granted this cycle.
REQ-016 mem_rvalid_i  input  1  granted transaction completed.
REQ-017 core_rst_n_o  output  1  low holds core in reset while loading.
REQ-018 busy_o  output  1  load in progress.
REQ-019 done_o  output  1  load finished (sticky until next start).
REQ-020 err_o  output  1  length exceeded memory (sticky until next start).

Function
REQ-021 States SHALL be IDLE, LEN, DATA, REQ, ACK, DONE.
REQ-022 IDLE: byte_ready_o=0, core_rst_n_o=1; start_i -> LEN, clears done_o/err_o, address counter := BASE_ADDR.
REQ-023 LEN: byte_ready_o=1; 4 bytes assembled little-endian (first byte = bits 7:0) into 32-bit word count N.
REQ-024 After 4th LEN byte: N=0 -> DONE; N > 2^(ADDR_WIDTH-2) - BASE_ADDR/4 -> err_o=1, DONE, no memory writes; else -> DATA.
REQ-025 DATA: byte_ready_o=1; 4 bytes assembled little-endian into wdata; after 4th byte -> REQ next cycle.
REQ-026 REQ: mem_req_o=1 with addr/we/be/wdata stable until mem_gnt_i=1 sampled; byte_ready_o=0; gnt -> ACK.
REQ-027 ACK: mem_req_o=0; wait mem_rvalid_i=1; then address += 4, remaining count -= 1; remaining 0 -> DONE else DATA.
REQ-028 Minimum per-word cost: 4 byte cycles + 1 REQ cycle + 1 ACK cycle (gnt and rvalid each in earliest cycle).
REQ-029 mem_rvalid_i asserted outside ACK SHALL be ignored; mem_gnt_i outside REQ SHALL be ignored.
REQ-030 busy_o=1 and core_rst_n_o=0 in LEN, DATA, REQ, ACK; both deasserted in IDLE and DONE.
REQ-031 DONE: done_o=1; start_i -> LEN (restart, clears done_o/err_o); otherwise stay.
REQ-032 start_i while busy_o=1 SHALL be ignored.
REQ-033 Bytes with byte_valid_i=0 SHALL not advance the byte-lane counter; gaps of any length allowed.
REQ-034 Address counter SHALL never wrap; REQ-024 guarantees last address <= 2^ADDR_WIDTH-4.

Reset
REQ-035 On rst_n=0 (any state, including mid-REQ): state IDLE, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, byte_ready_o=0, busy_o=0, done_o=0, err_o=0, core_rst_n_o=0 while rst_n=0, all counters 0.
REQ-036 After rst_n release, core_rst_n_o SHALL be 1 from the first clock edge onward in IDLE.

Verification
REQ-037 start; bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00 with gnt/rvalid immediate -> writes 0x00000013 @0x0000, 0x0000006F @0x0004; done_o=1, core_rst_n_o=1.
REQ-038 start; N=0 (00 00 00 00) -> no mem_req_o, done_o=1 two cycles after 4th byte... precisely: DONE next cycle, err_o=0.
REQ-039 start; N=0x00004001 with ADDR_WIDTH=16, BASE_ADDR=0 -> err_o=1, done_o=1, mem_req_o never asserted.
REQ-040 N=1, gnt withheld 5 cycles -> mem_req_o/addr/wdata stable all 5 cycles, one write only; rvalid delayed 3 cycles -> stays ACK, byte_ready_o=0.
REQ-041 rst_n pulsed low while in REQ -> mem_req_o=0 immediately (async), IDLE, done_o=0; subsequent full load succeeds from BASE_ADDR.
REQ-042 start_i pulsed during DATA -> ignored, load completes with correct count; start_i in DONE -> restart, done_o cleared.
